// File: rtl/bitty_param_pkg.sv
// bitty_param_pkg: shared state, op-code, format and compare-result definitions
package bitty_param_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXEC, ST_WB} state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_CMP = 4'd7
    } op_t;

    localparam logic [1:0] FMT_RR  = 2'b00;
    localparam logic [1:0] FMT_IMM = 2'b01;

    localparam logic [1:0] CMP_EQ = 2'd0;
    localparam logic [1:0] CMP_GT = 2'd1;
    localparam logic [1:0] CMP_LT = 2'd2;

endpackage

// File: rtl/bitty_param_if.sv
// bitty_param_if: instruction offer/accept handshake between issuer and core
interface bitty_param_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (output instr, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/bitty_alu_p.sv
// bitty_alu_p: combinational ALU; carry is the add carry-out or the sub borrow
module bitty_alu_p
    import bitty_param_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             illegal
);
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH:0]  sum;
    logic [WIDTH:0]  diff;
    logic [SW-1:0]   sh;

    // Compute all candidate results and select by op; op 8..15 is flagged illegal
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        sh      = b[SW-1:0];
        illegal = op[3];
        carry   = (op == OP_SUB) ? diff[WIDTH] : sum[WIDTH];
        case (op)
            OP_ADD:  result = sum[WIDTH-1:0];
            OP_SUB:  result = diff[WIDTH-1:0];
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << sh;
            OP_SHR:  result = a >> sh;
            OP_CMP:  result = (a == b) ? WIDTH'(CMP_EQ) : (a > b) ? WIDTH'(CMP_GT) : WIDTH'(CMP_LT);
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/bitty_param_core.sv
// bitty_param_core: four-state (IDLE/LOAD/EXEC/WB) register-machine core
module bitty_param_core
    import bitty_param_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    bitty_param_if.slave     bus,
    input  logic             init_en,
    input  logic [RW-1:0]    init_addr,
    input  logic [WIDTH-1:0] init_data,
    input  logic [RW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic             done,
    output logic             err,
    output logic             carry,
    output logic             busy
);
    state_t           state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] s_q, s_d, b_q, b_d, c_q, c_d;
    logic [3:0]       op_q, op_d;
    logic             ill_q, ill_d, cout_q, cout_d, carry_q, carry_d;
    logic             done_q, done_d, err_q, err_d, busy_q, busy_d;

    logic [RW-1:0]    rx, ry;
    logic [1:0]       fmt;
    logic [WIDTH-1:0] imm, alu_res;
    logic             alu_cout, alu_ill;

    assign rx  = ir_q[13 +: RW];
    assign ry  = ir_q[10 +: RW];
    assign fmt = ir_q[1:0];
    assign imm = WIDTH'(ir_q[12:5]);

    assign bus.instr_ready = (state_q == ST_IDLE) && !init_en;
    assign dbg_data        = regs_q[dbg_addr];
    assign done            = done_q;
    assign err             = err_q;
    assign carry           = carry_q;
    assign busy            = busy_q;

    bitty_alu_p #(.WIDTH(WIDTH)) u_alu (
        .a       (s_q),
        .b       (b_q),
        .op      (op_q),
        .result  (alu_res),
        .carry   (alu_cout),
        .illegal (alu_ill)
    );

    // Next-state logic: preload/accept in IDLE, operand fetch in LOAD, ALU capture in EXEC, commit in WB
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        regs_d  = regs_q;
        s_d     = s_q;
        b_d     = b_q;
        c_d     = c_q;
        op_d    = op_q;
        ill_d   = ill_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (init_en)
                    regs_d[init_addr] = init_data;
                else if (bus.instr_valid) begin
                    ir_d    = bus.instr;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_d     = regs_q[rx];
                b_d     = (fmt == FMT_IMM) ? imm : regs_q[ry];
                op_d    = (fmt == FMT_IMM) ? {1'b0, ir_q[4:2]} : ir_q[5:2];
                ill_d   = fmt[1];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                c_d     = alu_res;
                cout_d  = alu_cout;
                ill_d   = ill_q | alu_ill;
                done_d  = 1'b1;
                err_d   = ill_q | alu_ill;
                state_d = ST_WB;
            end
            default: begin
                if (!ill_q) begin
                    regs_d[rx] = c_q;
                    carry_d    = (op_q == OP_ADD || op_q == OP_SUB) ? cout_q : carry_q;
                end
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; asynchronous reset aborts any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            regs_q  <= '{default: '0};
            s_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            op_q    <= '0;
            ill_q   <= 1'b0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            regs_q  <= regs_d;
            s_q     <= s_d;
            b_q     <= b_d;
            c_q     <= c_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_bitty_param_core.sv
// tb_bitty_param_core: directed checks of a 16-bit/8-reg core and an 8-bit/4-reg core
module tb_bitty_param_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          n_cmp = 0;
    int          n_fail = 0;

    logic        init_en_a = 1'b0, init_en_b = 1'b0;
    logic [2:0]  init_addr_a = '0, dbg_addr_a = '0;
    logic [1:0]  init_addr_b = '0, dbg_addr_b = '0;
    logic [15:0] init_data_a = '0, dbg_data_a;
    logic [7:0]  init_data_b = '0, dbg_data_b;
    logic        done_a, err_a, carry_a, busy_a;
    logic        done_b, err_b, carry_b, busy_b;

    bitty_param_if ifa ();
    bitty_param_if ifb ();

    bitty_param_core #(.WIDTH(16), .NREGS(8)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa),
        .init_en(init_en_a), .init_addr(init_addr_a), .init_data(init_data_a),
        .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a),
        .done(done_a), .err(err_a), .carry(carry_a), .busy(busy_a)
    );

    bitty_param_core #(.WIDTH(8), .NREGS(4)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb),
        .init_en(init_en_b), .init_addr(init_addr_b), .init_data(init_data_b),
        .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b),
        .done(done_b), .err(err_b), .carry(carry_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rr(input logic [2:0] x, input logic [2:0] y, input logic [3:0] op);
        return {x, y, 4'b0000, op, 2'b00};
    endfunction

    function automatic logic [15:0] im(input logic [2:0] x, input logic [7:0] v, input logic [2:0] op);
        return {x, v, op, 2'b01};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pre_a(input logic [2:0] a, input logic [15:0] d);
        init_en_a = 1'b1; init_addr_a = a; init_data_a = d;
        step();
        init_en_a = 1'b0;
    endtask

    task automatic rd_a(input string tag, input logic [2:0] a, input logic [15:0] exp);
        dbg_addr_a = a;
        #1;
        chk(tag, 32'(dbg_data_a), 32'(exp));
    endtask

    // Handshake at cycle t, done at t+3, back in IDLE at t+4
    task automatic issue_a(input string tag, input logic [15:0] ins, input logic exp_err);
        ifa.instr = ins; ifa.instr_valid = 1'b1;
        #1;
        chk({tag, ".ready"}, 32'(ifa.instr_ready), 32'd1);
        step();
        ifa.instr_valid = 1'b0;
        chk({tag, ".busy1"}, 32'(busy_a), 32'd1);
        chk({tag, ".nodone1"}, 32'(done_a), 32'd0);
        step();
        chk({tag, ".nodone2"}, 32'(done_a), 32'd0);
        step();
        chk({tag, ".done3"}, 32'(done_a), 32'd1);
        chk({tag, ".err3"}, 32'(err_a), 32'(exp_err));
        step();
        chk({tag, ".done4"}, 32'(done_a), 32'd0);
        chk({tag, ".idle4"}, 32'(busy_a), 32'd0);
    endtask

    initial begin
        ifa.instr = '0; ifa.instr_valid = 1'b0;
        ifb.instr = '0; ifb.instr_valid = 1'b0;
        step();
        step();
        chk("rst.done", 32'(done_a), 32'd0);
        chk("rst.err", 32'(err_a), 32'd0);
        chk("rst.busy", 32'(busy_a), 32'd0);
        chk("rst.carry", 32'(carry_a), 32'd0);
        chk("rst.ready", 32'(ifa.instr_ready), 32'd1);
        rd_a("rst.r0", 3'd0, 16'h0000);
        reset = 1'b0;
        step();

        pre_a(3'd0, 16'd5);
        pre_a(3'd1, 16'd3);
        issue_a("add", rr(3'd0, 3'd1, 4'd0), 1'b0);
        rd_a("add.r0", 3'd0, 16'd8);
        rd_a("add.r1", 3'd1, 16'd3);
        chk("add.carry", 32'(carry_a), 32'd0);

        pre_a(3'd2, 16'h0001);
        pre_a(3'd3, 16'h0002);
        issue_a("sub", rr(3'd2, 3'd3, 4'd1), 1'b0);
        rd_a("sub.r2", 3'd2, 16'hFFFF);
        chk("sub.borrow", 32'(carry_a), 32'd1);
        issue_a("addi", im(3'd2, 8'd1, 3'd0), 1'b0);
        rd_a("addi.r2", 3'd2, 16'h0000);
        chk("addi.carry", 32'(carry_a), 32'd1);

        pre_a(3'd4, 16'd7);
        pre_a(3'd5, 16'd9);
        issue_a("cmplt", rr(3'd4, 3'd5, 4'd7), 1'b0);
        rd_a("cmplt.r4", 3'd4, 16'd2);
        issue_a("cmpeq", im(3'd5, 8'd9, 3'd7), 1'b0);
        rd_a("cmpeq.r5", 3'd5, 16'd0);
        chk("cmp.carry_held", 32'(carry_a), 32'd1);

        issue_a("fmt10", {3'd0, 3'd1, 4'b0000, 4'd0, 2'b10}, 1'b1);
        rd_a("fmt10.r0", 3'd0, 16'd8);
        rd_a("fmt10.r1", 3'd1, 16'd3);
        chk("fmt10.carry", 32'(carry_a), 32'd1);
        issue_a("op9", rr(3'd1, 3'd0, 4'd9), 1'b1);
        rd_a("op9.r1", 3'd1, 16'd3);

        pre_a(3'd6, 16'h00F0);
        pre_a(3'd7, 16'h0F0F);
        issue_a("xor", rr(3'd6, 3'd7, 4'd4), 1'b0);
        rd_a("xor.r6", 3'd6, 16'h0FFF);
        issue_a("shr", im(3'd6, 8'd4, 3'd6), 1'b0);
        rd_a("shr.r6", 3'd6, 16'h00FF);
        issue_a("shl", im(3'd6, 8'h14, 3'd5), 1'b0);
        rd_a("shl.r6", 3'd6, 16'h0FF0);
        issue_a("andi", im(3'd7, 8'h0F, 3'd2), 1'b0);
        rd_a("andi.r7", 3'd7, 16'h000F);
        issue_a("ori", im(3'd7, 8'hA0, 3'd3), 1'b0);
        rd_a("ori.r7", 3'd7, 16'h00AF);
        issue_a("self", rr(3'd7, 3'd7, 4'd0), 1'b0);
        rd_a("self.r7", 3'd7, 16'h015E);
        chk("self.carry", 32'(carry_a), 32'd0);

        ifa.instr = im(3'd1, 8'd2, 3'd0); ifa.instr_valid = 1'b1;
        step();
        ifa.instr = im(3'd1, 8'd1, 3'd0);
        chk("b2b.ready1", 32'(ifa.instr_ready), 32'd0);
        step();
        step();
        chk("b2b.done1", 32'(done_a), 32'd1);
        step();
        chk("b2b.ready2", 32'(ifa.instr_ready), 32'd1);
        rd_a("b2b.mid_r1", 3'd1, 16'd5);
        step();
        ifa.instr_valid = 1'b0;
        step();
        step();
        chk("b2b.done2", 32'(done_a), 32'd1);
        step();
        rd_a("b2b.r1", 3'd1, 16'd6);

        ifa.instr = im(3'd0, 8'd1, 3'd0); ifa.instr_valid = 1'b1;
        step();
        ifa.instr_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("abort.done", 32'(done_a), 32'd0);
        chk("abort.busy", 32'(busy_a), 32'd0);
        rd_a("abort.r0", 3'd0, 16'd0);
        rd_a("abort.r7", 3'd7, 16'd0);
        chk("abort.carry", 32'(carry_a), 32'd0);
        step();
        chk("abort.done_hold", 32'(done_a), 32'd0);
        reset = 1'b0;
        step();
        issue_a("post", im(3'd0, 8'd5, 3'd0), 1'b0);
        rd_a("post.r0", 3'd0, 16'd5);

        init_en_a = 1'b1; init_addr_a = 3'd3; init_data_a = 16'h0040;
        ifa.instr = im(3'd3, 8'd1, 3'd0); ifa.instr_valid = 1'b1;
        #1;
        chk("coll.ready0", 32'(ifa.instr_ready), 32'd0);
        step();
        init_en_a = 1'b0;
        chk("coll.busy0", 32'(busy_a), 32'd0);
        rd_a("coll.pre_r3", 3'd3, 16'h0040);
        issue_a("coll", im(3'd3, 8'd1, 3'd0), 1'b0);
        rd_a("coll.r3", 3'd3, 16'h0041);

        init_en_b = 1'b1; init_addr_b = 2'd2; init_data_b = 8'h81;
        ifb.instr = im(3'd6, 8'd1, 3'd5); ifb.instr_valid = 1'b1;
        #1;
        chk("b.ready0", 32'(ifb.instr_ready), 32'd0);
        step();
        init_en_b = 1'b0;
        #1;
        chk("b.ready1", 32'(ifb.instr_ready), 32'd1);
        step();
        ifb.instr_valid = 1'b0;
        chk("b.busy", 32'(busy_b), 32'd1);
        step();
        step();
        chk("b.done", 32'(done_b), 32'd1);
        chk("b.err", 32'(err_b), 32'd0);
        step();
        dbg_addr_b = 2'd2;
        #1;
        chk("b.r2", 32'(dbg_data_b), 32'h02);
        chk("b.carry", 32'(carry_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bitty_param_core.md
BITTY_PARAM_CORE -- requirements
Module: bitty_param_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width (8..32).
REQ-002 SHALL have parameter NREGS, default 8, general registers (2, 4 or 8); RW = clog2(NREGS).
REQ-003 SHALL have ports `clk` (in, 1, single clock) and `reset` (in, 1); reset is asynchronous and active-high.
REQ-004 SHALL have ports `instr` in 16 (instruction word), `instr_valid` in 1 (offer), `instr_ready` out 1 (accept).
REQ-005 SHALL have ports `init_en` in 1 (register preload strobe), `init_addr` in RW, `init_data` in WIDTH.
REQ-006 SHALL have ports `dbg_addr` in RW, `dbg_data` out WIDTH (combinational read of R[dbg_addr]).
REQ-007 SHALL have ports `done` out 1 (instruction retired), `err` out 1 (illegal instruction), `carry` out 1, `busy` out 1.

Function
REQ-008 Instruction fields SHALL be: Rx=instr[15:13], Ry=instr[12:10], fmt=instr[1:0]; register index = low RW bits of Rx/Ry.
REQ-009 fmt 00 SHALL be reg-reg: B=R[Ry], op=instr[5:2].
REQ-010 fmt 01 SHALL be immediate: B=zero-extended instr[12:5] (truncated if WIDTH<8), op={1'b0,instr[4:2]}.
REQ-011 fmt 10/11, or op 8..15, SHALL be illegal.
REQ-012 Ops SHALL be: 0 add, 1 sub (A-B), 2 and, 3 or, 4 xor, 5 shl by B[clog2(WIDTH)-1:0], 6 logical shr (same amount), 7 cmp (0 equal, 1 A>B, 2 A<B, unsigned).
REQ-013 Results SHALL wrap modulo 2^WIDTH; carry SHALL update only on add (carry-out) and sub (1 = borrow) and hold otherwise.
REQ-014 FSM states SHALL be IDLE, LOAD, EXEC, WB.
REQ-015 IDLE: instr_ready=1 iff init_en=0; a handshake (valid&ready) SHALL latch instr and go to LOAD.
REQ-016 LOAD: S <= R[Rx]; decode; go to EXEC.
REQ-017 EXEC: C <= alu(S,B), flags computed; go to WB.
REQ-018 WB: legal -> R[Rx] <= C; done=1 for this single cycle; err=1 in this cycle if illegal (no register or carry write); go to IDLE.
REQ-019 Latency: handshake in cycle t SHALL give done in t+3; result visible on dbg_data from t+4; throughput one instruction per 4 cycles.
REQ-020 busy SHALL be 1 in LOAD/EXEC/WB, 0 in IDLE.
REQ-021 init_en SHALL write R[init_addr] <= init_data only in IDLE; ignored in other states; in IDLE it blocks the instruction handshake in that cycle.
REQ-022 Back-to-back: instr_valid held high through WB SHALL be accepted in the next IDLE cycle.
REQ-023 Rx==Ry SHALL use the pre-instruction value for both operands.

Reset
REQ-024 Reset SHALL clear all R[], S, C, carry and instruction register to 0, force IDLE; done=err=busy=0, instr_ready=1 (when init_en=0).
REQ-025 Reset mid-instruction SHALL abort with no register write and no done pulse.

Structure
REQ-026 Package bitty_param_pkg SHALL hold the state enum, op-code enum, fmt constants and cmp result codes.
REQ-027 ALU SHALL be a sub-module bitty_alu_p parametrised by WIDTH (pure combinational: a, b, op -> result, carry, illegal).
REQ-028 Register file, S, C and FSM SHALL live in bitty_param_core.

Verification
REQ-029 Preload R0=5, R1=3; fmt00 add Rx=0,Ry=1 -> done at t+3, R0=8, carry=0.
REQ-030 WIDTH=16, R2=0x0001, R3=0x0002; sub Rx=2,Ry=3 -> R2=0xFFFF, carry=1; then add-immediate 1 to R2 -> R2=0x0000, carry=1.
REQ-031 cmp R4=7 vs R5=9 -> R4=2; cmp R5=9 vs imm 9 -> R5=0.
REQ-032 instr with fmt=10 -> err=1 and done=1 at t+3, all registers unchanged, carry unchanged.
REQ-033 Assert reset during EXEC -> no done pulse, all registers 0, next instruction accepted normally.
REQ-034 init_en and instr_valid high together in IDLE -> preload applied, instr_ready=0 that cycle, instruction accepted next cycle; repeat with NREGS=4, WIDTH=8 (shl 0x81 by 1 -> 0x02).
